// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver feeding a show-ahead byte FIFO for the CPU's
// keyboard MMIO path. Deframes 11-bit device-to-host frames, checks odd
// parity and the stop bit, and aborts stalled frames after a timeout.
`timescale 1ns/1ps

module ps2_rx_fifo #(
  parameter int DEPTH_LOG2     = 3,
  parameter int TIMEOUT_CYCLES = 200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       read_enable,
  output logic [7:0] data,
  output logic       ready,
  output logic       overflow,
  output logic       frame_err
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);

  typedef logic [DEPTH_LOG2-1:0] ptr_t;
  typedef logic [DEPTH_LOG2:0]   cnt_t;
  typedef logic [TW-1:0]         tmo_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    CHECK = 2'd2
  } state_t;

  logic [1:0] clk_sync_q, clk_sync_d;
  logic [1:0] data_sync_q, data_sync_d;
  logic       clk_prev_q, clk_prev_d;
  state_t     state_q, state_d;
  logic [3:0] bitcnt_q, bitcnt_d;
  logic [9:0] shift_q, shift_d;
  tmo_t       timeout_q, timeout_d;
  logic [7:0] mem_q [DEPTH];
  logic [7:0] mem_d [DEPTH];
  ptr_t       wr_ptr_q, wr_ptr_d;
  ptr_t       rd_ptr_q, rd_ptr_d;
  cnt_t       count_q, count_d;
  logic       overflow_q, overflow_d;

  logic fe;
  logic bit_in;
  logic good_frame;
  logic timeout_hit;
  logic push_req;
  logic err_raw;
  logic full;
  logic pop;
  logic push;

  // Synchronize both PS/2 pins and derive a one-cycle falling-edge strobe.
  always_comb begin
    clk_sync_d  = {clk_sync_q[0], ps2_clk};
    data_sync_d = {data_sync_q[0], ps2_data};
    clk_prev_d  = clk_sync_q[1];
    fe          = clk_prev_q & ~clk_sync_q[1];
    bit_in      = data_sync_q[1];
    // After ten shifts bit 9 holds the stop bit and bits 8:0 are data plus parity.
    good_frame  = shift_q[9] & (^shift_q[8:0]);
    timeout_hit = (state_q == RECV) && !fe && (timeout_q == tmo_t'(TIMEOUT_CYCLES - 1));
  end

  // Next-state logic of the frame FSM.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (fe && !bit_in) state_d = RECV;
      end
      RECV: begin
        if (timeout_hit)                    state_d = IDLE;
        else if (fe && bitcnt_q == 4'd9)    state_d = CHECK;
      end
      CHECK: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Shift register, bit counter and inactivity timer for the frame in flight.
  always_comb begin
    bitcnt_d  = bitcnt_q;
    shift_d   = shift_q;
    timeout_d = '0;
    case (state_q)
      IDLE: bitcnt_d = '0;
      RECV: begin
        if (timeout_hit) begin
          bitcnt_d = '0;
          shift_d  = '0;
        end else if (fe) begin
          shift_d  = {bit_in, shift_q[9:1]};
          bitcnt_d = bitcnt_q + 4'd1;
        end else begin
          timeout_d = timeout_q + tmo_t'(1);
        end
      end
      CHECK: bitcnt_d = '0;
      default: bitcnt_d = '0;
    endcase
  end

  // FSM outputs: push request for good frames, error strobe for rejects and aborts.
  always_comb begin
    push_req = 1'b0;
    err_raw  = 1'b0;
    case (state_q)
      IDLE:  err_raw = fe & bit_in;
      RECV:  err_raw = timeout_hit;
      CHECK: begin
        push_req = good_frame;
        err_raw  = ~good_frame;
      end
      default: err_raw = 1'b0;
    endcase
    frame_err = rst & err_raw;
  end

  // Show-ahead FIFO bookkeeping; a push into a full FIFO only succeeds alongside a pop.
  always_comb begin
    full       = (count_q == cnt_t'(DEPTH));
    pop        = read_enable && (count_q != '0);
    push       = push_req && (!full || pop);
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (push) begin
      mem_d[wr_ptr_q] = shift_q[7:0];
      wr_ptr_d        = wr_ptr_q + ptr_t'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + ptr_t'(1);
    if (push && !pop)      count_d = count_q + cnt_t'(1);
    else if (pop && !push) count_d = count_q - cnt_t'(1);
    if (push_req && full) begin
      if (!pop) overflow_d = 1'b1;
    end else if (pop) begin
      overflow_d = 1'b0;
    end
    data     = mem_q[rd_ptr_q];
    ready    = (count_q != '0);
    overflow = overflow_q;
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      clk_prev_q  <= 1'b1;
      state_q     <= IDLE;
      bitcnt_q    <= '0;
      shift_q     <= '0;
      timeout_q   <= '0;
      mem_q       <= '{default: '0};
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
    end else begin
      clk_sync_q  <= clk_sync_d;
      data_sync_q <= data_sync_d;
      clk_prev_q  <= clk_prev_d;
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      shift_q     <= shift_d;
      timeout_q   <= timeout_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
    end
  end

endmodule
